// File: rtl/r_release_scheduler.sv
// -----------------------------------------------------------------------------
// r_release_scheduler
//
// Purpose:
//   Round-robin scheduler that picks which UID of the per-UID R response
//   memory is drained next. It drives the memory's uid_to_free select and
//   gates the R handshake between the memory and the master side. Once a UID
//   is granted, the scheduler stays locked on it from its first beat until
//   its RLAST beat, so bursts never interleave on the output.
//
// Handshake:
//   While locked (busy=1): out_valid follows mem_valid, mem_ready follows
//   out_ready, and a beat moves (xfer) on a rising edge where
//   mem_valid & out_ready. While idle, both out_valid and mem_ready are 0 and
//   no beat can move. The grant cycle never carries a beat, so back-to-back
//   bursts are separated by one bubble cycle.
//
// Optional feature (compile-time macro R_STORE_AND_FORWARD_EN):
//   defined   : a UID is eligible only when it is pending AND its whole burst
//               is buffered (uid_done), so the output never stalls mid-burst.
//   undefined : cut-through; uid_done is ignored and a UID is eligible as
//               soon as its first beat lands.
//
// Ports:
//   clk          in   1          clock
//   rst_n        in   1          synchronous active-low reset
//   uid_pending  in   NUM_UIDS   bit u = FIFO[u] non-empty
//   uid_done     in   NUM_UIDS   bit u = RLAST of FIFO[u] burst already stored
//   mem_valid    in   1          head-beat valid of the selected UID
//   mem_last     in   1          head-beat last of the selected UID
//   mem_ready    out  1          pop strobe qualifier to the memory
//   out_valid    out  1          R valid to the master side
//   out_ready    in   1          R ready from the master side
//   uid_to_free  out  ID_WIDTH   registered UID select to the memory
//   busy         out  1          FSM in LOCK (also the FSM state debug view)
//   beat_idx     out  BC_W       beats already transferred in current burst
//   err_overrun  out  1          sticky: MAX_BEATS beats moved without last
// -----------------------------------------------------------------------------
module r_release_scheduler #(
  parameter  int NUM_UIDS  = 16,
  parameter  int ID_WIDTH  = 4,
  parameter  int MAX_BEATS = 8,
  localparam int BC_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_UIDS-1:0] uid_pending,
  input  logic [NUM_UIDS-1:0] uid_done,
  input  logic                mem_valid,
  input  logic                mem_last,
  output logic                mem_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_WIDTH-1:0] uid_to_free,
  output logic                busy,
  output logic [BC_W-1:0]     beat_idx,
  output logic                err_overrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // UID count in the widened (ID_WIDTH+1) domain used for wrap arithmetic.
  localparam logic [ID_WIDTH:0] NUM_W    = (ID_WIDTH + 1)'(NUM_UIDS);
  localparam logic [BC_W-1:0]   BEAT_MAX = BC_W'(MAX_BEATS - 1);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] uid_q, uid_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]     beat_q, beat_d;
  logic                err_q, err_d;

  logic [NUM_UIDS-1:0] eligible;
  logic                found;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH:0]   cand;
  logic [ID_WIDTH:0]   uid_inc;
  logic [ID_WIDTH-1:0] rr_after;
  logic                locked;
  logic                xfer;

  // ---------------------------------------------------------------------------
  // Eligibility
  // ---------------------------------------------------------------------------
`ifdef R_STORE_AND_FORWARD_EN
  assign eligible = uid_pending & uid_done;
`else
  // Cut-through: completion status does not influence arbitration.
  logic unused_uid_done;
  assign unused_uid_done = ^uid_done;
  assign eligible        = uid_pending;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin search: first eligible UID at rr_ptr, rr_ptr+1, ... wrapping
  // at NUM_UIDS. The candidate is formed one bit wider so the wrap works for
  // NUM_UIDS that are not a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_UIDS; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(i);
      if (cand >= NUM_W) begin
        cand = cand - NUM_W;
      end
      if (!found && eligible[cand[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Pointer value after finishing (or aborting) the burst of uid_q.
  assign uid_inc  = {1'b0, uid_q} + (ID_WIDTH + 1)'(1);
  assign rr_after = (uid_inc == NUM_W) ? '0 : uid_inc[ID_WIDTH-1:0];

  assign locked = (state_q == ST_LOCK);
  assign xfer   = locked & mem_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    uid_d    = uid_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        // Grant takes effect on the next edge; no beat moves this cycle.
        if (found) begin
          uid_d   = pick;
          state_d = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // Pending/done changes are ignored here: no preemption. With
        // mem_valid low (FIFO underrun) there is no xfer and the lock holds.
        if (xfer) begin
          if (mem_last) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            rr_ptr_d = rr_after;
          end else if (beat_q == BEAT_MAX) begin
            // MAX_BEATS beats without last: flag it and release the lock so
            // one runaway UID cannot starve the others.
            err_d    = 1'b1;
            state_d  = ST_IDLE;
            beat_d   = '0;
            rr_ptr_d = rr_after;
          end else begin
            beat_d = beat_q + BC_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset abandons any lock; the memory contents are not
  // touched by this block.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      uid_q    <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      uid_q    <= uid_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The handshake outputs are also forced low while rst_n is
  // asserted so nothing pops during reset even if the lock was held.
  // ---------------------------------------------------------------------------
  assign busy        = locked;
  assign uid_to_free = uid_q;
  assign beat_idx    = beat_q;
  assign err_overrun = err_q;
  assign out_valid   = locked & rst_n & mem_valid;
  assign mem_ready   = locked & rst_n & out_ready;

endmodule

// File: tb/tb_r_release_scheduler.sv
// -----------------------------------------------------------------------------
// tb_r_release_scheduler
//
// Directed bench for r_release_scheduler with the default parameters
// (NUM_UIDS=16, ID_WIDTH=4, MAX_BEATS=8). Inputs are driven on the falling
// edge and outputs sampled 1 time unit later, so each table row shows the
// registered state left by the previous rising edge plus the combinational
// handshake outputs for the row's inputs.
// -----------------------------------------------------------------------------
module tb_r_release_scheduler;

  localparam int NUM_UIDS  = 16;
  localparam int ID_WIDTH  = 4;
  localparam int MAX_BEATS = 8;
  localparam int BC_W      = $clog2(MAX_BEATS + 1);

`ifdef R_STORE_AND_FORWARD_EN
  localparam logic [3:0] EXP_FIRST = 4'd4;
`else
  localparam logic [3:0] EXP_FIRST = 4'd0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_UIDS-1:0] uid_pending;
  logic [NUM_UIDS-1:0] uid_done;
  logic                mem_valid;
  logic                mem_last;
  logic                mem_ready;
  logic                out_valid;
  logic                out_ready;
  logic [ID_WIDTH-1:0] uid_to_free;
  logic                busy;
  logic [BC_W-1:0]     beat_idx;
  logic                err_overrun;

  always #5 clk = ~clk;

  r_release_scheduler #(
    .NUM_UIDS (NUM_UIDS),
    .ID_WIDTH (ID_WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uid_pending(uid_pending),
    .uid_done   (uid_done),
    .mem_valid  (mem_valid),
    .mem_last   (mem_last),
    .mem_ready  (mem_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .uid_to_free(uid_to_free),
    .busy       (busy),
    .beat_idx   (beat_idx),
    .err_overrun(err_overrun)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst_n;
    logic [15:0] pend;
    logic [15:0] done;
    logic        mv;
    logic        ml;
    logic        ordy;
    logic        e_busy;
    logic [3:0]  e_uid;
    logic [3:0]  e_beat;
    logic        e_ov;
    logic        e_mr;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [15:0] p, input logic [15:0] d,
                     input logic mv, input logic ml, input logic ordy,
                     input logic b, input logic [3:0] u, input logic [3:0] bt,
                     input logic ov, input logic mr, input logic er);
    vec_t v;
    v.rst_n = r;  v.pend = p;    v.done = d;
    v.mv = mv;    v.ml = ml;     v.ordy = ordy;
    v.e_busy = b; v.e_uid = u;   v.e_beat = bt;
    v.e_ov = ov;  v.e_mr = mr;   v.e_err = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [15:0] p, input logic [15:0] d,
                       input logic mv, input logic ml, input logic ordy);
    rst_n = r; uid_pending = p; uid_done = d;
    mem_valid = mv; mem_last = ml; out_ready = ordy;
  endtask

  task automatic build_table();
    //   rst  pend     done     mv  ml  ordy  busy uid  beat ov  mr  err
    // Reset held 3 cycles with everything pending.
    add(0, 16'hFFFF, 16'hFFFF, 1, 0, 1,   0, 0, 0, 0, 0, 0);
    add(0, 16'hFFFF, 16'hFFFF, 1, 0, 1,   0, 0, 0, 0, 0, 0);
    add(0, 16'hFFFF, 16'hFFFF, 1, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 16'h0000, 16'h0000, 1, 0, 1,   0, 0, 0, 0, 0, 0);
    // Single 4-beat burst on UID 3.
    add(1, 16'h0008, 16'h0008, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 16'h0008, 16'h0008, 1, 0, 1,   1, 3, 0, 1, 1, 0);
    add(1, 16'h0008, 16'h0008, 1, 0, 1,   1, 3, 1, 1, 1, 0);
    add(1, 16'h0008, 16'h0008, 1, 0, 1,   1, 3, 2, 1, 1, 0);
    add(1, 16'h0008, 16'h0008, 1, 1, 1,   1, 3, 3, 1, 1, 0);
    // rr_ptr is now 4: with 3 and 5 pending, 5 wins.
    add(1, 16'h0028, 16'h0028, 0, 0, 1,   0, 3, 0, 0, 0, 0);
    add(1, 16'h0000, 16'h0000, 1, 1, 1,   1, 5, 0, 1, 1, 0);
    // Backpressure and underrun on UID 7; pending changes ignored.
    add(1, 16'h0080, 16'h0080, 0, 0, 1,   0, 5, 0, 0, 0, 0);
    add(1, 16'h0080, 16'h0080, 1, 0, 1,   1, 7, 0, 1, 1, 0);
    add(1, 16'h0080, 16'h0080, 1, 0, 0,   1, 7, 1, 1, 0, 0);
    add(1, 16'hFFFF, 16'hFFFF, 0, 0, 0,   1, 7, 1, 0, 0, 0);
    add(1, 16'h0080, 16'h0080, 1, 0, 0,   1, 7, 1, 1, 0, 0);
    add(1, 16'h0080, 16'h0080, 1, 0, 1,   1, 7, 1, 1, 1, 0);
    add(1, 16'h0080, 16'h0080, 1, 1, 1,   1, 7, 2, 1, 1, 0);
    // Overrun on UID 1 (pointer wraps from 8 to 1): 8 beats, no last.
    add(1, 16'h0002, 16'h0002, 0, 0, 1,   0, 7, 0, 0, 0, 0);
    for (int i = 0; i < MAX_BEATS; i++)
      add(1, 16'h0002, 16'h0002, 1, 0, 1, 1, 1, 4'(i), 1, 1, 0);
    // Back in IDLE, err sticky, rr_ptr=2 so UID 2 beats UID 1.
    add(1, 16'h0006, 16'h0006, 0, 0, 1,   0, 1, 0, 0, 0, 1);
    add(1, 16'h0000, 16'h0000, 1, 1, 1,   1, 2, 0, 1, 1, 1);
    // Reset to bring rr_ptr back to 0, then store-and-forward selection.
    add(0, 16'h0000, 16'h0000, 0, 0, 1,   0, 2, 0, 0, 0, 1);
    add(1, 16'h0011, 16'h0010, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 16'h0000, 16'h0000, 1, 0, 1,   1, EXP_FIRST, 0, 1, 1, 0);
    // Reset mid-burst: handshake outputs drop immediately, lock abandoned.
    add(0, 16'h0000, 16'h0000, 1, 0, 1,   1, EXP_FIRST, 1, 0, 0, 0);
    add(1, 16'h0000, 16'h0000, 0, 0, 1,   0, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    drive(0, 16'hFFFF, 16'hFFFF, 1, 0, 1);
    @(posedge clk);
    build_table();

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst_n, vecs[k].pend, vecs[k].done,
            vecs[k].mv, vecs[k].ml, vecs[k].ordy);
      #1;
      check($sformatf("v%0d_busy", k),      32'(busy),        32'(vecs[k].e_busy));
      check($sformatf("v%0d_uid", k),       32'(uid_to_free), 32'(vecs[k].e_uid));
      check($sformatf("v%0d_beat", k),      32'(beat_idx),    32'(vecs[k].e_beat));
      check($sformatf("v%0d_out_valid", k), 32'(out_valid),   32'(vecs[k].e_ov));
      check($sformatf("v%0d_mem_ready", k), 32'(mem_ready),   32'(vecs[k].e_mr));
      check($sformatf("v%0d_err", k),       32'(err_overrun), 32'(vecs[k].e_err));
    end

    // Round robin between UIDs 2 and 5, 2-beat bursts, pointer starts at 0.
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd5);
    end
    for (int b = 0; b < 6; b++) begin
      logic       got;
      logic [3:0] exp_uid;
      logic [3:0] first_uid;
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        @(negedge clk);
        drive(1, 16'h0024, 16'h0024, 1, 0, 1);
        #1;
        if (busy) got = 1'b1;
      end
      exp_uid = exp_q.pop_front();
      check($sformatf("rr%0d_granted", b), 32'(got), 32'd1);
      if (!got) continue;
      first_uid = uid_to_free;
      check($sformatf("rr%0d_uid", b),   32'(uid_to_free), 32'(exp_uid));
      check($sformatf("rr%0d_beat0", b), 32'(beat_idx),    32'd0);
      @(negedge clk);
      mem_last = 1'b1;
      #1;
      check($sformatf("rr%0d_contig", b), 32'(uid_to_free), 32'(first_uid));
      check($sformatf("rr%0d_beat1", b),  32'(beat_idx),    32'd1);
      check($sformatf("rr%0d_busy1", b),  32'(busy),        32'd1);
    end
    // After the final last beat the scheduler must be idle again.
    @(negedge clk);
    drive(1, 16'h0000, 16'h0000, 0, 0, 1);
    #1;
    check("rr_end_idle", 32'(busy), 32'd0);

    // Single pending UID is re-granted every burst (pointer now 6, UID 9 only).
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive(1, 16'h0200, 16'h0200, 0, 0, 1);
      #1;
      check($sformatf("single%0d_idle", b), 32'(busy), 32'd0);
      @(negedge clk);
      drive(1, 16'h0200, 16'h0200, 1, 1, 1);
      #1;
      check($sformatf("single%0d_uid", b),  32'(uid_to_free), 32'd9);
      check($sformatf("single%0d_busy", b), 32'(busy),        32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
